// File: rtl/test_monitor.sv
// Snoops core register-file write-back to detect end-of-test, waits a settle
// window, then latches a sticky pass/fail/timeout verdict with a watchdog.
module test_monitor #(
    parameter int unsigned DW             = 32,
    parameter int unsigned DONE_REG       = 26,
    parameter int unsigned PASS_REG       = 27,
    parameter int unsigned NUM_REG        = 3,
    parameter int unsigned SETTLE_CYCLES  = 20,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [4:0]    waddr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [2:0]    state_o,
    output logic          done_o,
    output logic          pass_o,
    output logic          fail_o,
    output logic          timeout_o,
    output logic [DW-1:0] testnum_o,
    output logic [31:0]   cycle_cnt_o
);

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    localparam int unsigned   SETTLE_EFF  = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
    localparam logic [31:0]   SETTLE_LAST = 32'(SETTLE_EFF - 1);
    localparam logic [31:0]   TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);
    localparam logic          WDOG_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic          DONE_OK     = (DONE_REG != 0) && (DONE_REG < 32);
    localparam logic          PASS_OK     = (PASS_REG != 0) && (PASS_REG < 32);
    localparam logic          NUM_OK      = (NUM_REG != 0) && (NUM_REG < 32);
    localparam logic [DW-1:0] ONE         = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [31:0]   CNT_MAX     = 32'hFFFF_FFFF;

    state_t        state_r;
    logic [DW-1:0] done_sh_r;
    logic [DW-1:0] pass_sh_r;
    logic [DW-1:0] num_sh_r;
    logic [31:0]   settle_cnt_r;
    logic [31:0]   cyc_r;
    logic          pass_r;
    logic          fail_r;
    logic          timeout_r;

    logic          active_s;
    logic          wr_done_s;
    logic          wr_pass_s;
    logic          wr_num_s;
    logic [DW-1:0] done_next_s;
    logic [DW-1:0] pass_next_s;
    logic [31:0]   cyc_inc_s;
    logic          wdog_hit_s;

    // Write decode and next-value views of the shadows (a write on this edge wins)
    always_comb begin
        active_s    = (state_r == ST_RUN) || (state_r == ST_SETTLE);
        wr_done_s   = we_i && active_s && DONE_OK && (waddr_i == 5'(DONE_REG));
        wr_pass_s   = we_i && active_s && PASS_OK && (waddr_i == 5'(PASS_REG));
        wr_num_s    = we_i && active_s && NUM_OK  && (waddr_i == 5'(NUM_REG));
        done_next_s = wr_done_s ? wdata_i : done_sh_r;
        pass_next_s = wr_pass_s ? wdata_i : pass_sh_r;
        if (cyc_r == CNT_MAX) begin
            cyc_inc_s = cyc_r;
        end else begin
            cyc_inc_s = cyc_r + 32'd1;
        end
        // Fires only on the edge where the count actually steps onto the limit
        wdog_hit_s = WDOG_EN && (cyc_r != TIMEOUT_LIM) && (cyc_inc_s == TIMEOUT_LIM);
    end

    // Shadows, counters, FSM and verdict flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_RUN;
            done_sh_r    <= '0;
            pass_sh_r    <= '0;
            num_sh_r     <= '0;
            settle_cnt_r <= 32'd0;
            cyc_r        <= 32'd0;
            pass_r       <= 1'b0;
            fail_r       <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            if (active_s) begin
                done_sh_r <= done_next_s;
                pass_sh_r <= pass_next_s;
                if (wr_num_s) begin
                    num_sh_r <= wdata_i;
                end
                cyc_r <= cyc_inc_s;
            end
            case (state_r)
                ST_RUN: begin
                    // In RUN the done shadow can never already hold 1, so this is the write itself
                    if (done_next_s == ONE) begin
                        state_r      <= ST_SETTLE;
                        settle_cnt_r <= 32'd0;
                    end else if (wdog_hit_s) begin
                        state_r   <= ST_TIMEOUT;
                        timeout_r <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        if (pass_next_s == ONE) begin
                            state_r <= ST_PASS;
                            pass_r  <= 1'b1;
                        end else begin
                            state_r <= ST_FAIL;
                            fail_r  <= 1'b1;
                        end
                    end else if (wdog_hit_s) begin
                        state_r   <= ST_TIMEOUT;
                        timeout_r <= 1'b1;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 32'd1;
                    end
                end
                ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                    state_r <= state_r;
                end
                default: begin
                    state_r   <= ST_RUN;
                    pass_r    <= 1'b0;
                    fail_r    <= 1'b0;
                    timeout_r <= 1'b0;
                end
            endcase
        end
    end

    assign state_o     = state_r;
    assign pass_o      = pass_r;
    assign fail_o      = fail_r;
    assign timeout_o   = timeout_r;
    assign done_o      = pass_r | fail_r | timeout_r;
    assign testnum_o   = num_sh_r;
    assign cycle_cnt_o = cyc_r;

endmodule

// File: tb/tb_test_monitor.sv
// Directed bench for test_monitor: a default instance (settle 20) and a
// second instance with a 50-cycle watchdog, sharing the same stimulus.
module tb_test_monitor;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    logic [2:0]  state_a, state_b;
    logic        done_a, pass_a, fail_a, tmo_a;
    logic        done_b, pass_b, fail_b, tmo_b;
    logic [31:0] num_a, num_b, cyc_a, cyc_b;

    int n_chk;
    int n_pass;

    test_monitor dut_a (
        .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .state_o(state_a), .done_o(done_a), .pass_o(pass_a), .fail_o(fail_a),
        .timeout_o(tmo_a), .testnum_o(num_a), .cycle_cnt_o(cyc_a)
    );

    test_monitor #(.TIMEOUT_CYCLES(50)) dut_b (
        .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .state_o(state_b), .done_o(done_b), .pass_o(pass_b), .fail_o(fail_b),
        .timeout_o(tmo_b), .testnum_o(num_b), .cycle_cnt_o(cyc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Presents a write at the current negedge; it is sampled by the next posedge.
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        @(negedge clk);
        we = 1'b0; waddr = 5'd0; wdata = 32'd0;
    endtask

    task automatic do_reset;
        rst = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'd0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'hAB;
        tick(2);
        n_chk++; if (state_a !== 3'd0) $display("FAIL reset_state got=%0d exp=0", state_a); else n_pass++;
        n_chk++; if ({done_a, pass_a, fail_a, tmo_a} !== 4'b0000) $display("FAIL reset_flags got=%b exp=0000", {done_a, pass_a, fail_a, tmo_a}); else n_pass++;
        n_chk++; if (num_a !== 32'd0) $display("FAIL reset_testnum got=%0h exp=0", num_a); else n_pass++;
        n_chk++; if (cyc_a !== 32'd0) $display("FAIL reset_cyc got=%0d exp=0", cyc_a); else n_pass++;
        we = 1'b0; waddr = 5'd0; wdata = 32'd0;
        rst = 1'b0;
    endtask

    task automatic test_pass;
        do_reset();
        wr(5'd3, 32'd5); wr(5'd27, 32'd1); wr(5'd26, 32'd1);
        n_chk++; if (state_a !== 3'd1) $display("FAIL pass_enter_settle got=%0d exp=1", state_a); else n_pass++;
        tick(19);
        n_chk++; if (done_a !== 1'b0) $display("FAIL pass_early_done got=%b exp=0", done_a); else n_pass++;
        tick(1);
        n_chk++; if ({state_a, done_a, pass_a, fail_a, tmo_a} !== {3'd2, 4'b1100}) $display("FAIL pass_verdict got=%0d/%b exp=2/1100", state_a, {done_a, pass_a, fail_a, tmo_a}); else n_pass++;
        n_chk++; if (num_a !== 32'd5) $display("FAIL pass_testnum got=%0d exp=5", num_a); else n_pass++;
        wr(5'd3, 32'd9); tick(3);
        n_chk++; if (num_a !== 32'd5) $display("FAIL pass_frozen_testnum got=%0d exp=5", num_a); else n_pass++;
        n_chk++; if (cyc_a !== 32'd23) $display("FAIL pass_cyc_hold got=%0d exp=23", cyc_a); else n_pass++;
    endtask

    task automatic test_fail;
        do_reset();
        wr(5'd3, 32'd7); wr(5'd27, 32'd0); wr(5'd26, 32'd1);
        tick(20);
        n_chk++; if ({state_a, done_a, pass_a, fail_a, tmo_a} !== {3'd3, 4'b1010}) $display("FAIL fail_verdict got=%0d/%b exp=3/1010", state_a, {done_a, pass_a, fail_a, tmo_a}); else n_pass++;
        n_chk++; if (num_a !== 32'd7) $display("FAIL fail_testnum got=%0d exp=7", num_a); else n_pass++;
    endtask

    task automatic test_late_pass;
        do_reset();
        wr(5'd26, 32'd1); tick(19);
        n_chk++; if (state_a !== 3'd1) $display("FAIL late_still_settle got=%0d exp=1", state_a); else n_pass++;
        wr(5'd27, 32'd1);
        n_chk++; if ({pass_a, fail_a} !== 2'b10) $display("FAIL late_pass got=%b exp=10", {pass_a, fail_a}); else n_pass++;
        do_reset();
        wr(5'd26, 32'd1); tick(20);
        wr(5'd27, 32'd1); tick(2);
        n_chk++; if ({state_a, pass_a, fail_a} !== {3'd3, 2'b01}) $display("FAIL too_late got=%0d/%b exp=3/01", state_a, {pass_a, fail_a}); else n_pass++;
    endtask

    task automatic test_timeout;
        do_reset();
        tick(49);
        n_chk++; if ({tmo_b, cyc_b} !== {1'b0, 32'd49}) $display("FAIL tmo_before got=%b/%0d exp=0/49", tmo_b, cyc_b); else n_pass++;
        tick(1);
        n_chk++; if ({state_b, done_b, tmo_b, cyc_b} !== {3'd4, 1'b1, 1'b1, 32'd50}) $display("FAIL tmo_hit got=%0d/%b/%b/%0d exp=4/1/1/50", state_b, done_b, tmo_b, cyc_b); else n_pass++;
        tick(5); wr(5'd26, 32'd1); tick(2);
        n_chk++; if ({state_b, pass_b, fail_b, tmo_b, cyc_b} !== {3'd4, 3'b001, 32'd50}) $display("FAIL tmo_sticky got=%0d/%b/%0d exp=4/001/50", state_b, {pass_b, fail_b, tmo_b}, cyc_b); else n_pass++;
    endtask

    task automatic test_corners;
        do_reset();
        wr(5'd3, 32'h11); wr(5'd26, 32'd2); tick(3);
        n_chk++; if (state_a !== 3'd0) $display("FAIL done_two_run got=%0d exp=0", state_a); else n_pass++;
        wr(5'd0, 32'd1); tick(2);
        n_chk++; if ({state_a, num_a} !== {3'd0, 32'h11}) $display("FAIL x0_ignored got=%0d/%0h exp=0/11", state_a, num_a); else n_pass++;
        // Second done write and a test-number update mid-settle
        wr(5'd26, 32'd1); tick(10); wr(5'd26, 32'd1); wr(5'd3, 32'h33); tick(7);
        n_chk++; if ({state_a, num_a} !== {3'd1, 32'h33}) $display("FAIL settle_no_restart got=%0d/%0h exp=1/33", state_a, num_a); else n_pass++;
        tick(1);
        n_chk++; if (state_a !== 3'd3) $display("FAIL settle_verdict got=%0d exp=3", state_a); else n_pass++;
        do_reset();
        wr(5'd26, 32'd1); tick(5);
        rst = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'h77;
        tick(1);
        n_chk++; if ({state_a, done_a, pass_a, fail_a, tmo_a, num_a, cyc_a} !== {3'd0, 4'b0000, 32'd0, 32'd0}) $display("FAIL rst_mid_settle got=%0d/%b/%0h/%0d exp=0/0000/0/0", state_a, {done_a, pass_a, fail_a, tmo_a}, num_a, cyc_a); else n_pass++;
        we = 1'b0; waddr = 5'd0; wdata = 32'd0; rst = 1'b0;
        tick(49); wr(5'd26, 32'd1);
        n_chk++; if ({state_b, tmo_b} !== {3'd1, 1'b0}) $display("FAIL done_and_tmo got=%0d/%b exp=1/0", state_b, tmo_b); else n_pass++;
        tick(20);
        n_chk++; if ({state_b, fail_b, tmo_b, cyc_b} !== {3'd3, 1'b1, 1'b0, 32'd70}) $display("FAIL done_and_tmo_verdict got=%0d/%b/%b/%0d exp=3/1/0/70", state_b, fail_b, tmo_b, cyc_b); else n_pass++;
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'd0;
        test_reset();
        test_pass();
        test_fail();
        test_late_pass();
        test_timeout();
        test_corners();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
